// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM stage of the 5-stage core.
//   EXE_out_t  : bundle arriving from the EXE stage
//   MEM_out_t  : registered bundle handed to write-back
//   mem_state_t: MEM stage FSM states
//   dmem_req_t : data-memory request fields captured in the hold register
//   F3_*       : load/store func3 encodings
//   acc_size() : maps func3 to an access width (unlisted encodings are words)
package mem_access_stage_pkg;

  typedef struct packed {
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        Wmem;
    logic        Rmem;
    logic        Wreg;
    logic [2:0]  func3;
  } EXE_out_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] result;
    logic        Wreg;
    logic        Rmem;
  } MEM_out_t;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dmem_req_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_t;

  function automatic acc_size_t acc_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: acc_size = SZ_B;
      F3_H, F3_HU: acc_size = SZ_H;
      F3_W:        acc_size = SZ_W;
      default:     acc_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_lsu_align.sv
// lsu_align: combinational lane steering for the data-memory port.
//   func3     in   access type
//   addr_lo   in   byte offset within the word
//   rs2       in   store source register
//   rdata     in   word returned by memory
//   be        out  byte enables
//   wdata     out  store data replicated across lanes
//   load_data out  selected lane, sign/zero-extended to 32 bits
module lsu_align
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v    = rdata[{addr_lo, 3'b000} +: 8];
    half_v    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    be        = 4'hF;
    wdata     = rs2;
    load_data = rdata;
    // func3[2] marks the unsigned load variants
    case (acc_size(func3))
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{rs2[7:0]}};
        load_data = func3[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      SZ_H: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata     = {2{rs2[15:0]}};
        load_data = func3[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage. Issues data-memory requests, waits out
// variable latency with an IDLE/WAIT FSM, stalls upstream while waiting,
// formats loads and registers a MEM_out_t for write-back.
// Optional build macro: MEM_MISALIGN_TRAP_EN (trap misaligned H/W accesses).
// Ports:
//   clk, nRst              clock, asynchronous active-low reset
//   in_valid, exe_in       live EXE bundle
//   flush                  kill the instruction at the stage output
//   dmem_req/we/addr/be/wdata, dmem_ack, dmem_rdata   data-memory bus
//   stall_o                hold IF/DEC/EXE
//   mem_out, out_valid     registered write-back bundle
//   err_o                  one-cycle pulse on timeout or misalign trap
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        in_valid,
  input  EXE_out_t    exe_in,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_o,
  output MEM_out_t    mem_out,
  output logic        out_valid,
  output logic        err_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  mem_state_t       state;
  logic [CNT_W-1:0] to_cnt;
  dmem_req_t        hold_req;
  logic [4:0]       hold_rd;
  logic [31:0]      hold_addr;
  logic [2:0]       hold_f3;
  logic             hold_wreg;
  logic             hold_flush;

  MEM_out_t mem_out_p1;
  logic     vld_p1;
  logic     err_p1;

  logic        is_wait, mem_op, misalign, issue, timeout_hit, kill;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_wdata, lsu_load;
  logic [4:0]  cur_rd;
  logic [31:0] cur_addr;
  logic        cur_we, cur_wreg;
  MEM_out_t    done_out;

  assign is_wait = (state == WAIT);
  assign mem_op  = in_valid & (exe_in.Rmem | exe_in.Wmem);

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (acc_size(exe_in.func3))
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = exe_in.result[0];
      default: misalign = |exe_in.result[1:0];
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign issue = mem_op & ~misalign;
  // Fires on the last permitted WAIT cycle so the abandon lands at the same
  // edge the counter would reach TIMEOUT_CYCLES; an ack in that cycle wins.
  assign timeout_hit = is_wait & ~dmem_ack & TO_EN & (to_cnt == CNT_LAST);
  // A flush seen at any point during WAIT is remembered until completion.
  assign kill = flush | (is_wait & hold_flush);

  lsu_align u_lsu (
    .func3     (is_wait ? hold_f3 : exe_in.func3),
    .addr_lo   (is_wait ? hold_addr[1:0] : exe_in.result[1:0]),
    .rs2       (exe_in.rs2),
    .rdata     (dmem_rdata),
    .be        (lsu_be),
    .wdata     (lsu_wdata),
    .load_data (lsu_load)
  );

  always_comb begin
    dmem_req = nRst & (is_wait | issue);
    if (is_wait) begin
      dmem_we    = hold_req.we;
      dmem_addr  = hold_req.addr;
      dmem_be    = hold_req.be;
      dmem_wdata = hold_req.wdata;
    end else begin
      dmem_we    = exe_in.Wmem;
      dmem_addr  = {exe_in.result[31:2], 2'b00};
      dmem_be    = lsu_be;
      dmem_wdata = lsu_wdata;
    end
    stall_o = nRst & ~dmem_ack & (is_wait ? ~timeout_hit : issue);
  end

  always_comb begin
    cur_rd   = is_wait ? hold_rd   : exe_in.rd;
    cur_addr = is_wait ? hold_addr : exe_in.result;
    cur_we   = is_wait ? hold_req.we : exe_in.Wmem;
    cur_wreg = is_wait ? hold_wreg : exe_in.Wreg;
    done_out = '{rd: cur_rd, result: cur_we ? cur_addr : lsu_load,
                 Wreg: cur_wreg & ~cur_we & ~kill, Rmem: ~cur_we};
  end

  // Stage boundary: hold register captured when an access enters WAIT
  always_ff @(posedge clk) begin
    if (!is_wait && issue && !dmem_ack) begin
      hold_req  <= '{we: exe_in.Wmem, addr: {exe_in.result[31:2], 2'b00},
                     be: lsu_be, wdata: lsu_wdata};
      hold_rd   <= exe_in.rd;
      hold_addr <= exe_in.result;
      hold_f3   <= exe_in.func3;
      hold_wreg <= exe_in.Wreg;
    end
  end

  // Stage boundary: FSM, timeout counter and write-back register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      to_cnt     <= '0;
      hold_flush <= 1'b0;
      mem_out_p1 <= '0;
      vld_p1     <= 1'b0;
      err_p1     <= 1'b0;
    end else begin
      err_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (!in_valid) begin
            vld_p1 <= 1'b0;
          end else if (!mem_op) begin
            mem_out_p1 <= '{rd: exe_in.rd, result: exe_in.result,
                            Wreg: exe_in.Wreg & ~flush, Rmem: 1'b0};
            vld_p1     <= ~flush;
          end else if (misalign) begin
            mem_out_p1 <= '{rd: exe_in.rd, result: exe_in.result,
                            Wreg: 1'b0, Rmem: exe_in.Rmem & ~exe_in.Wmem};
            vld_p1     <= ~flush;
            err_p1     <= 1'b1;
          end else if (dmem_ack) begin
            mem_out_p1 <= done_out;
            vld_p1     <= ~flush;
          end else begin
            vld_p1     <= 1'b0;
            state      <= WAIT;
            to_cnt     <= '0;
            hold_flush <= flush;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            mem_out_p1 <= done_out;
            vld_p1     <= ~kill;
            state      <= IDLE;
          end else if (timeout_hit) begin
            mem_out_p1 <= '{rd: hold_rd, result: hold_addr, Wreg: 1'b0,
                            Rmem: ~hold_req.we};
            vld_p1     <= ~kill;
            err_p1     <= 1'b1;
            state      <= IDLE;
          end else begin
            vld_p1     <= 1'b0;
            to_cnt     <= to_cnt + 1'b1;
            hold_flush <= hold_flush | flush;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_out   = mem_out_p1;
  assign out_valid = vld_p1;
  assign err_o     = err_p1;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk;
  logic        nRst;
  logic        in_valid;
  EXE_out_t    exe_in;
  logic        flush;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        stall_o;
  MEM_out_t    mem_out;
  logic        out_valid, err_o;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .nRst(nRst), .in_valid(in_valid), .exe_in(exe_in), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_o(stall_o), .mem_out(mem_out), .out_valid(out_valid), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic EXE_out_t mk(input logic [31:0] rs2, input logic [4:0] rd,
                                  input logic [31:0] res, input logic wm, input logic rm,
                                  input logic wr, input logic [2:0] f3);
    mk = '{rs2: rs2, rd: rd, result: res, Wmem: wm, Rmem: rm, Wreg: wr, func3: f3};
  endfunction

  // Load acknowledged in its issue cycle: no stall, result next edge.
  task automatic imm_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rd_word, input logic [31:0] exp);
    in_valid = 1'b1; exe_in = mk(32'h0, 5'd7, addr, 1'b0, 1'b1, 1'b1, f3);
    dmem_ack = 1'b1; dmem_rdata = rd_word;
    #1;
    check({tag, "_req"}, dmem_req, 1);
    check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    check({tag, "_stall"}, stall_o, 0);
    tick;
    in_valid = 1'b0; dmem_ack = 1'b0;
    check({tag, "_res"}, mem_out.result, exp);
    check({tag, "_wreg"}, mem_out.Wreg, 1);
    check({tag, "_vld"}, out_valid, 1);
  endtask

  // Store acknowledged in its issue cycle.
  task automatic imm_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rs2, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd);
    in_valid = 1'b1; exe_in = mk(rs2, 5'd8, addr, 1'b1, 1'b0, 1'b1, f3);
    dmem_ack = 1'b1;
    #1;
    check({tag, "_we"}, dmem_we, 1);
    check({tag, "_be"}, dmem_be, exp_be);
    check({tag, "_wdata"}, dmem_wdata, exp_wd);
    tick;
    in_valid = 1'b0; dmem_ack = 1'b0;
    check({tag, "_res"}, mem_out.result, addr);
    check({tag, "_wreg"}, mem_out.Wreg, 0);
    check({tag, "_vld"}, out_valid, 1);
  endtask

  initial begin
    nRst = 1'b0; in_valid = 1'b0; exe_in = '0; flush = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    tick; tick;
    check("rst_vld", out_valid, 0);
    check("rst_mem_out", mem_out.result, 0);
    check("rst_err", err_o, 0);
    check("rst_req", dmem_req, 0);
    check("rst_stall", stall_o, 0);
    nRst = 1'b1;
    tick;

    // Pass-through ALU op
    in_valid = 1'b1; exe_in = mk(32'h0, 5'd5, 32'h1234, 1'b0, 1'b0, 1'b1, F3_W);
    #1;
    check("pt_req", dmem_req, 0);
    check("pt_stall", stall_o, 0);
    tick;
    in_valid = 1'b0;
    check("pt_rd", mem_out.rd, 5);
    check("pt_res", mem_out.result, 32'h1234);
    check("pt_wreg", mem_out.Wreg, 1);
    check("pt_rmem", mem_out.Rmem, 0);
    check("pt_vld", out_valid, 1);
    tick;
    check("bubble_vld", out_valid, 0);

    // Pass-through flushed at its registering edge
    in_valid = 1'b1; flush = 1'b1;
    exe_in = mk(32'h0, 5'd6, 32'h55, 1'b0, 1'b0, 1'b1, F3_W);
    tick;
    in_valid = 1'b0; flush = 1'b0;
    check("ptfl_vld", out_valid, 0);
    check("ptfl_wreg", mem_out.Wreg, 0);

    // Immediate-ack loads
    imm_load("lb",  F3_B,   32'h1003, 32'h80FF_FFFF, 32'hFFFF_FF80);
    imm_load("lbu", F3_BU,  32'h1001, 32'h0000_F500, 32'h0000_00F5);
    imm_load("lh",  F3_H,   32'h1002, 32'h8001_0000, 32'hFFFF_8001);
    imm_load("lhu", F3_HU,  32'h1000, 32'h1234_8765, 32'h0000_8765);
    imm_load("lw",  F3_W,   32'h1004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    imm_load("l011", 3'b011, 32'h1008, 32'h1122_3344, 32'h1122_3344);
    check("lb_rmem", mem_out.Rmem, 1);

    // Immediate-ack stores
    imm_store("sb", F3_B, 32'h2001, 32'h1234_5677, 4'b0010, 32'h7777_7777);
    imm_store("sw", F3_W, 32'h2008, 32'hCAFE_F00D, 4'hF,    32'hCAFE_F00D);

    // SH with ack on the third cycle after issue
    in_valid = 1'b1; exe_in = mk(32'h0000_ABCD, 5'd9, 32'h2002, 1'b1, 1'b0, 1'b1, F3_H);
    #1;
    check("sh_req0", dmem_req, 1);
    check("sh_be0", dmem_be, 4'b1100);
    check("sh_wd0", dmem_wdata, 32'hABCD_ABCD);
    check("sh_stall0", stall_o, 1);
    for (int i = 1; i <= 2; i++) begin
      tick;
      // Disturb exe_in: bus must keep driving the held request.
      exe_in = mk(32'h1111_2222, 5'd1, 32'h7771, 1'b0, 1'b1, 1'b1, F3_B);
      #1;
      check("sh_req_w", dmem_req, 1);
      check("sh_we_w", dmem_we, 1);
      check("sh_addr_w", dmem_addr, 32'h2000);
      check("sh_be_w", dmem_be, 4'b1100);
      check("sh_wd_w", dmem_wdata, 32'hABCD_ABCD);
      check("sh_stall_w", stall_o, 1);
      check("sh_vld_w", out_valid, 0);
    end
    tick;
    dmem_ack = 1'b1;
    #1;
    check("sh_stall_ack", stall_o, 0);
    check("sh_be_ack", dmem_be, 4'b1100);
    tick;
    in_valid = 1'b0; dmem_ack = 1'b0;
    check("sh_vld", out_valid, 1);
    check("sh_wreg", mem_out.Wreg, 0);
    check("sh_res", mem_out.result, 32'h2002);
    check("sh_rd", mem_out.rd, 9);

    // LW timeout with ack withheld (TIMEOUT_CYCLES = 4)
    in_valid = 1'b1; exe_in = mk(32'h0, 5'd3, 32'h3000, 1'b0, 1'b1, 1'b1, F3_W);
    #1;
    check("to_stall0", stall_o, 1);
    for (int i = 1; i <= 4; i++) begin
      tick;
      check("to_req_w", dmem_req, 1);
      check("to_err_w", err_o, 0);
      if (i < 4) check("to_stall_w", stall_o, 1);
    end
    tick;
    in_valid = 1'b0;
    #1;
    check("to_req_drop", dmem_req, 0);
    check("to_stall_rel", stall_o, 0);
    check("to_err", err_o, 1);
    check("to_vld", out_valid, 1);
    check("to_wreg", mem_out.Wreg, 0);
    tick;
    check("to_err_once", err_o, 0);

    // Flush during WAIT of LHU, then ack: bus completes, output discarded
    in_valid = 1'b1; exe_in = mk(32'h0, 5'd4, 32'h4002, 1'b0, 1'b1, 1'b1, F3_HU);
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    #1;
    check("fl_req_kept", dmem_req, 1);
    check("fl_stall", stall_o, 1);
    tick;
    dmem_ack = 1'b1; dmem_rdata = 32'h9876_0000;
    #1;
    check("fl_req_ack", dmem_req, 1);
    tick;
    in_valid = 1'b0; dmem_ack = 1'b0;
    check("fl_vld", out_valid, 0);
    check("fl_wreg", mem_out.Wreg, 0);

    // Reset mid-WAIT
    in_valid = 1'b1; exe_in = mk(32'h0, 5'd2, 32'h5000, 1'b0, 1'b1, 1'b1, F3_W);
    tick;
    check("rw_stall", stall_o, 1);
    nRst = 1'b0;
    #1;
    check("rw_req", dmem_req, 0);
    check("rw_stall0", stall_o, 0);
    check("rw_vld", out_valid, 0);
    in_valid = 1'b0;
    tick;
    nRst = 1'b1;
    tick;
    check("rw_req_after", dmem_req, 0);
    check("rw_vld_after", out_valid, 0);

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned LW traps without a bus request
    in_valid = 1'b1; exe_in = mk(32'h0, 5'd10, 32'h3001, 1'b0, 1'b1, 1'b1, F3_W);
    #1;
    check("ma_req", dmem_req, 0);
    check("ma_stall", stall_o, 0);
    tick;
    in_valid = 1'b0;
    check("ma_err", err_o, 1);
    check("ma_vld", out_valid, 1);
    check("ma_wreg", mem_out.Wreg, 0);
    tick;
    check("ma_err_once", err_o, 0);
`else
    // Low address bits ignored: word access stays full-word
    in_valid = 1'b1; exe_in = mk(32'h0, 5'd10, 32'h3001, 1'b0, 1'b1, 1'b1, F3_W);
    dmem_ack = 1'b1; dmem_rdata = 32'hA5A5_0F0F;
    #1;
    check("ma_req", dmem_req, 1);
    check("ma_addr", dmem_addr, 32'h3000);
    check("ma_be", dmem_be, 4'hF);
    tick;
    in_valid = 1'b0; dmem_ack = 1'b0;
    check("ma_res", mem_out.result, 32'hA5A5_0F0F);
    check("ma_err", err_o, 0);
    // Halfword at odd address uses the lanes picked by addr[1]
    imm_load("lh_odd", F3_H, 32'h1003, 32'hC0DE_0000, 32'hFFFF_C0DE);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage core: consumes the EXE stage result bundle (EXE_out_t), drives the data-memory request/ack bus, aligns and extends loads, and registers a MEM_out_t for write-back.
- Absorbs variable memory latency with a small FSM.
- Raises a stall to freeze IF/DEC/EXE while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before the access is abandoned. 0 disables the timeout.

Ports:
- clk  in  1  core clock
- nRst  in  1  asynchronous active-low reset
- in_valid  in  1  exe_in holds a live instruction
- exe_in  in  EXE_out_t  EXE result bundle (rs2, rd, result/address, Wmem, Rmem, Wreg, func3)
- flush  in  1  kill the instruction at the stage output
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({result[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  request accepted/completed; read data valid in the same cycle
- dmem_rdata  in  32  read word
- stall_o  out  1  upstream hold
- mem_out  out  MEM_out_t  registered rd/result/Wreg/Rmem
- out_valid  out  1  mem_out is live
- err_o  out  1  one-cycle pulse on timeout (or misalign, see Optional Feature)

Behaviour:
- Reset (nRst=0, asynchronous):
  - state=IDLE; mem_out=0; out_valid=0; err_o=0; dmem_req=0; timeout counter=0.
  - Reset mid-WAIT abandons the access with no completion.
- Memory op: in_valid & (Rmem|Wmem). Otherwise the instruction is a pass-through: mem_out <= {rd, result, Wreg, Rmem=0} and out_valid <= 1 on the next edge. Latency is 1.
- IDLE, memory op present:
  - dmem_req=1 combinationally from exe_in.
  - If dmem_ack is seen in the same cycle: register the result at the edge, stay IDLE, stall_o=0.
  - Otherwise: latch the request into the hold register, go to WAIT, stall_o=1 in that cycle.
- WAIT:
  - dmem_req/we/addr/be/wdata are driven from the hold register and must stay stable.
  - stall_o=1.
  - On dmem_ack: register the result, go to IDLE, stall_o=0 in the ack cycle.
- Result formatting, selected by func3 and addr[1:0]:
  - LB (000) and LH (001) sign-extend; LBU (100) and LHU (101) zero-extend; LW (010) passes the full word.
  - Stores:
    - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
    - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}.
    - SW: be=4'hF.
  - func3 values 011/110/111 are treated as word accesses.
  - For stores, mem_out.Wreg=0 and result=address.
- Flush:
  - If flush is asserted at the registering edge: out_valid <= 0 and Wreg <= 0.
  - Flush during WAIT does not drop the bus transaction. The access completes, then is discarded.
- Timeout:
  - The counter increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES: dmem_req drops, state goes to IDLE, err_o pulses, out_valid <= 1 with Wreg=0, and stall releases.
  - The counter clears on entry to WAIT.
- Simultaneous ack and timeout in the same cycle: ack wins.
- out_valid holds 0 on any cycle with no incoming instruction (bubble).

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, issues no dmem_req.
  - err_o pulses next cycle; mem_out carries Wreg=0 and out_valid=1.
  - Latency is 1 with no stall.
- Undefined: the low address bits are ignored. The access proceeds using the lane/be mapping above. A word access is always full-word, and a halfword access with addr[0]=1 uses the lanes selected by addr[1].

Decomposition:
- Additions to core_types_pkg:
  - mem_state_t enum {IDLE, WAIT}.
  - func3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - dmem_req_t struct {we, addr, be, wdata} used for the hold register.
- One combinational sub-module, lsu_align: store lane/be generation and load extract/extend.
- The FSM, hold register, timeout counter and output register stay in mem_access_stage.

Test Plan:
- Pass-through ALU op: rd=5, result=0x1234, Wreg=1, no mem -> next edge mem_out={5,0x1234,1,0}, out_valid=1, dmem_req never asserted.
- LB at 0x1003 with dmem_rdata=0x80FF_FFFF and ack in the same cycle -> result=0xFFFF_FF80, no stall.
- SH at 0x2002 with rs2=0xABCD and ack after 3 cycles -> be=4'b1100, wdata=0xABCD_ABCD held stable; stall_o high for 3 cycles; then Wreg=0.
- LW with ack withheld, TIMEOUT_CYCLES=4 -> req drops after 4 WAIT cycles, err_o pulses once, Wreg=0, stall releases.
- flush during WAIT of LHU, then ack -> transaction completes on the bus; out_valid=0.
- nRst asserted mid-WAIT -> dmem_req=0 and stall_o=0 immediately. With MEM_MISALIGN_TRAP_EN: LW at 0x3001 -> no req, err_o pulse.
